bcd_countdown_timer: RTL and testbench

Parametrised multi-digit countdown timer that keeps its count directly in BCD, so no binary-to-BCD stage is needed and the digit count can scale. Time is set digit by digit with a cursor, then the timer is started, paused and resumed, and raises a done pulse and alarm level on expiry. It sits between the debounced button pulses and the multiplexed 7-segment driver, which consumes `bcd` and `cursor`.

---
 rtl/bcd_countdown_timer_pkg.sv | 21 ++
 rtl/bcd_countdown_timer_if.sv | 33 +++
 rtl/bcd_digit_dec.sv | 29 ++
 rtl/bcd_countdown_timer.sv | 139 +++++++++++++
 tb/tb_bcd_countdown_timer.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_countdown_timer_pkg.sv
// Shared definitions for the BCD countdown timer: state encodings, BCD
// digit limits and a single-digit modulo-10 increment helper.
package bcd_countdown_timer_pkg;

    typedef enum logic [1:0] {
        ST_SET   = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_ZERO = 4'd0;

    // Digit increment that wraps 9 -> 0 with no carry out. Anything above 9
    // also folds to 0 so an illegal nibble can never persist.
    function automatic logic [3:0] bcd_inc(input logic [3:0] d);
        return (d >= BCD_MAX) ? BCD_ZERO : d + 4'd1;
    endfunction

endpackage

// File: rtl/bcd_countdown_timer_if.sv
// Button/display bundle between the debounced buttons, the timer and the
// 7-segment driver.
//   btn_sel/btn_inc/btn_go/btn_clr : one-cycle button pulses into the timer
//   bcd     : packed BCD count, digit i on [4i+3:4i]
//   cursor  : one-hot edit position (zero outside SET)
//   running : high in RUN
//   alarm   : high in DONE
//   done    : one-cycle expiry pulse
interface bcd_countdown_timer_if #(
    parameter int DIGITS = 4
);
    logic                  btn_sel;
    logic                  btn_inc;
    logic                  btn_go;
    logic                  btn_clr;
    logic [4*DIGITS-1:0]   bcd;
    logic [DIGITS-1:0]     cursor;
    logic                  running;
    logic                  alarm;
    logic                  done;

    // master: button source / display consumer side
    modport master (
        output btn_sel, btn_inc, btn_go, btn_clr,
        input  bcd, cursor, running, alarm, done
    );

    // slave: the timer itself
    modport slave (
        input  btn_sel, btn_inc, btn_go, btn_clr,
        output bcd, cursor, running, alarm, done
    );
endinterface

// File: rtl/bcd_digit_dec.sv
// One BCD digit of the decrement borrow chain (combinational).
//   digit_i  : current digit value (0..9)
//   borrow_i : 1 = subtract one from this digit
//   digit_o  : resulting digit
//   borrow_o : 1 = this digit wrapped 0 -> 9 and borrows from the next one
module bcd_digit_dec
    import bcd_countdown_timer_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       borrow_i,
    output logic [3:0] digit_o,
    output logic       borrow_o
);
    always_comb begin
        digit_o  = digit_i;
        borrow_o = 1'b0;
        if (borrow_i) begin
            if (digit_i == BCD_ZERO) begin
                digit_o  = BCD_MAX;
                borrow_o = 1'b1;
            end else if (digit_i > BCD_MAX) begin
                // unreachable; clamps back into range rather than propagate
                digit_o  = BCD_MAX;
            end else begin
                digit_o  = digit_i - 4'd1;
            end
        end
    end
endmodule

// File: rtl/bcd_countdown_timer.sv
// Multi-digit countdown timer holding its count in BCD.
// Digits are edited with a cursor in SET, then the count runs down one step
// every TICK_DIV clocks, can be paused/resumed, and raises done/alarm at zero.
//   clk    : system clock
//   rst    : asynchronous, active-high reset
//   tmr_if : button inputs and bcd/cursor/running/alarm/done outputs
module bcd_countdown_timer
    import bcd_countdown_timer_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 100_000_000,
    parameter int CW       = 27
) (
    input  logic                          clk,
    input  logic                          rst,
    bcd_countdown_timer_if.slave          tmr_if
);
    localparam int              PW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0]   PRE_LAST = CW'(TICK_DIV - 1);
    localparam logic [PW-1:0]   POS_LAST = PW'(DIGITS - 1);

    state_e                 st_q,   st_d;
    logic [4*DIGITS-1:0]    bcd_q,  bcd_d;
    logic [PW-1:0]          pos_q,  pos_d;
    logic [CW-1:0]          pre_q,  pre_d;
    logic                   done_q, done_d;

    // Decremented count, always computed; only used on a tick.
    logic [4*DIGITS-1:0]    bcd_dec;
    logic [DIGITS:0]        borrow;

    assign borrow[0] = 1'b1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        bcd_digit_dec u_dig (
            .digit_i  (bcd_q[4*g +: 4]),
            .borrow_i (borrow[g]),
            .digit_o  (bcd_dec[4*g +: 4]),
            .borrow_o (borrow[g+1])
        );
    end

    logic tick;
    logic expire;

    assign tick   = (pre_q == PRE_LAST);
    // Count was exactly 1: the result is zero and nothing underflowed.
    assign expire = (bcd_dec == '0) && !borrow[DIGITS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q   <= ST_SET;
            bcd_q  <= '0;
            pos_q  <= '0;
            pre_q  <= '0;
            done_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            bcd_q  <= bcd_d;
            pos_q  <= pos_d;
            pre_q  <= pre_d;
            done_q <= done_d;
        end
    end

    always_comb begin
        st_d   = st_q;
        bcd_d  = bcd_q;
        pos_d  = pos_q;
        pre_d  = pre_q;
        done_d = 1'b0;

        if (tmr_if.btn_clr) begin
            st_d  = ST_SET;
            bcd_d = '0;
            pos_d = '0;
            pre_d = '0;
        end else begin
            unique case (st_q)
                ST_SET: begin
                    if (tmr_if.btn_go) begin
                        if (bcd_q != '0) begin
                            st_d  = ST_RUN;
                            pre_d = '0;
                        end
                    end else begin
                        // inc uses the old cursor even when sel moves it
                        if (tmr_if.btn_inc)
                            bcd_d[4*int'(pos_q) +: 4] = bcd_inc(bcd_q[4*int'(pos_q) +: 4]);
                        if (tmr_if.btn_sel)
                            pos_d = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (tmr_if.btn_go) begin
                        // pause wins over a coincident tick; prescaler holds
                        st_d = ST_PAUSE;
                    end else if (tick) begin
                        pre_d = '0;
                        bcd_d = bcd_dec;
                        if (expire) begin
                            st_d   = ST_DONE;
                            done_d = 1'b1;
                        end
                    end else begin
                        pre_d = pre_q + 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (tmr_if.btn_go)
                        st_d = ST_RUN;
                end
                ST_DONE: begin
                    if (tmr_if.btn_go || tmr_if.btn_sel || tmr_if.btn_inc) begin
                        st_d  = ST_SET;
                        bcd_d = '0;
                        pos_d = '0;
                        pre_d = '0;
                    end
                end
                default: st_d = ST_SET;
            endcase
        end
    end

    logic [DIGITS-1:0] cursor;

    always_comb begin
        cursor = '0;
        if (st_q == ST_SET)
            cursor[pos_q] = 1'b1;
    end

    assign tmr_if.bcd     = bcd_q;
    assign tmr_if.cursor  = cursor;
    assign tmr_if.running = (st_q == ST_RUN);
    assign tmr_if.alarm   = (st_q == ST_DONE);
    assign tmr_if.done    = done_q;
endmodule

// File: tb/tb_bcd_countdown_timer.sv
module tb_bcd_countdown_timer;
    localparam int DIGITS   = 2;
    localparam int TICK_DIV = 4;

    localparam int M_SET = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    bcd_countdown_timer_if #(.DIGITS(DIGITS)) bus ();

    bcd_countdown_timer #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .CW(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .tmr_if (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: count as a plain decimal integer.
    int m_st, m_val, m_pos, m_pre;
    bit m_done;

    function automatic int pow10(int p);
        int r = 1;
        for (int k = 0; k < p; k++) r = r * 10;
        return r;
    endfunction

    function automatic logic [4*DIGITS-1:0] to_bcd(int v);
        logic [4*DIGITS-1:0] r = '0;
        for (int k = 0; k < DIGITS; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
        return r;
    endfunction

    task automatic model_reset();
        m_st = M_SET; m_val = 0; m_pos = 0; m_pre = 0; m_done = 0;
    endtask

    task automatic model_step(input bit s, input bit i, input bit g, input bit c);
        int d;
        m_done = 0;
        if (c) begin
            m_st = M_SET; m_val = 0; m_pos = 0; m_pre = 0;
        end else if (m_st == M_SET) begin
            if (g) begin
                if (m_val != 0) begin m_st = M_RUN; m_pre = 0; end
            end else begin
                if (i) begin
                    d = (m_val / pow10(m_pos)) % 10;
                    m_val = m_val + (((d + 1) % 10) - d) * pow10(m_pos);
                end
                if (s) m_pos = (m_pos + 1) % DIGITS;
            end
        end else if (m_st == M_RUN) begin
            if (g) m_st = M_PAUSE;
            else begin
                m_pre++;
                if (m_pre == TICK_DIV) begin
                    m_pre = 0;
                    m_val--;
                    if (m_val == 0) begin m_st = M_DONE; m_done = 1; end
                end
            end
        end else if (m_st == M_PAUSE) begin
            if (g) m_st = M_RUN;
        end else begin
            if (s || i || g) begin m_st = M_SET; m_pos = 0; m_val = 0; end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        check("bcd",     32'(bus.bcd),     32'(to_bcd(m_val)));
        check("cursor",  32'(bus.cursor),  (m_st == M_SET) ? (32'd1 << m_pos) : 32'd0);
        check("running", 32'(bus.running), 32'(m_st == M_RUN));
        check("alarm",   32'(bus.alarm),   32'(m_st == M_DONE));
        check("done",    32'(bus.done),    32'(m_done));
    endtask

    // Apply buttons for one cycle, advance model, compare #1 after the edge.
    task automatic step(input bit s, input bit i, input bit g, input bit c);
        bus.btn_sel = s; bus.btn_inc = i; bus.btn_go = g; bus.btn_clr = c;
        @(posedge clk);
        model_step(s, i, g, c);
        #1;
        bus.btn_sel = 0; bus.btn_inc = 0; bus.btn_go = 0; bus.btn_clr = 0;
        cmp_model();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0);
    endtask

    task automatic set_val(input int v);
        step(0, 0, 0, 1);
        for (int k = 0; k < v % 10; k++) step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        for (int k = 0; k < (v / 10) % 10; k++) step(0, 1, 0, 0);
        step(1, 0, 0, 0);
    endtask

    typedef struct {
        bit s, i, g, c;
        int reps;
        logic [7:0] bcd;
        logic [1:0] cur;
        bit run, alm, dn;
    } vec_t;

    vec_t tbl[16];

    initial begin
        tbl[0]  = '{0,1,0,0, 1, 8'h01, 2'b01, 0,0,0};
        tbl[1]  = '{0,1,0,0, 1, 8'h02, 2'b01, 0,0,0};
        tbl[2]  = '{1,0,0,0, 1, 8'h02, 2'b10, 0,0,0};
        tbl[3]  = '{0,1,0,0, 1, 8'h12, 2'b10, 0,0,0};
        tbl[4]  = '{0,0,1,0, 1, 8'h12, 2'b00, 1,0,0};
        tbl[5]  = '{0,0,0,0, 3, 8'h12, 2'b00, 1,0,0};
        tbl[6]  = '{0,0,0,0, 1, 8'h11, 2'b00, 1,0,0};
        tbl[7]  = '{0,0,0,0, 4, 8'h10, 2'b00, 1,0,0};
        tbl[8]  = '{0,0,0,0, 4, 8'h09, 2'b00, 1,0,0};
        tbl[9]  = '{0,0,0,0,32, 8'h01, 2'b00, 1,0,0};
        tbl[10] = '{0,0,0,0, 3, 8'h01, 2'b00, 1,0,0};
        tbl[11] = '{0,0,0,0, 1, 8'h00, 2'b00, 0,1,1};
        tbl[12] = '{0,0,0,0, 1, 8'h00, 2'b00, 0,1,0};
        tbl[13] = '{0,0,0,0, 5, 8'h00, 2'b00, 0,1,0};
        tbl[14] = '{0,1,0,0, 1, 8'h00, 2'b01, 0,0,0};
        tbl[15] = '{0,1,0,0, 1, 8'h01, 2'b01, 0,0,0};

        bus.btn_sel = 0; bus.btn_inc = 0; bus.btn_go = 0; bus.btn_clr = 0;
        model_reset();
        #1;
        cmp_model();
        #11 rst = 1'b0;

        // Set 12, run to expiry, exit DONE with inc (not applied).
        foreach (tbl[n]) begin
            for (int k = 0; k < tbl[n].reps; k++)
                step(tbl[n].s, tbl[n].i, tbl[n].g, tbl[n].c);
            check($sformatf("tbl%0d.bcd", n),     32'(bus.bcd),     32'(tbl[n].bcd));
            check($sformatf("tbl%0d.cursor", n),  32'(bus.cursor),  32'(tbl[n].cur));
            check($sformatf("tbl%0d.running", n), 32'(bus.running), 32'(tbl[n].run));
            check($sformatf("tbl%0d.alarm", n),   32'(bus.alarm),   32'(tbl[n].alm));
            check($sformatf("tbl%0d.done", n),    32'(bus.done),    32'(tbl[n].dn));
        end

        // Go with a zero count is ignored.
        step(0, 0, 0, 1);
        step(0, 0, 1, 0);
        idle(10);
        check("zero_go.running", 32'(bus.running), 32'd0);
        check("zero_go.bcd",     32'(bus.bcd),     32'h00);

        // Pause with prescaler at 1, hold, resume: decrement 3 cycles later.
        set_val(5);
        step(0, 0, 1, 0);
        idle(5);
        check("pause.pre_bcd", 32'(bus.bcd), 32'h04);
        step(0, 0, 1, 0);
        idle(20);
        check("pause.hold_bcd", 32'(bus.bcd),     32'h04);
        check("pause.running",  32'(bus.running), 32'd0);
        step(0, 0, 1, 0);
        idle(2);
        check("resume.early", 32'(bus.bcd), 32'h04);
        idle(1);
        check("resume.tick",  32'(bus.bcd), 32'h03);

        // Digit wrap without carry, cursor wrap, clr beats go in RUN.
        step(0, 0, 0, 1);
        for (int k = 0; k < 10; k++) step(0, 1, 0, 0);
        check("wrap.bcd", 32'(bus.bcd), 32'h00);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("wrap.cursor", 32'(bus.cursor), 32'b01);
        set_val(23);
        step(0, 0, 1, 0);
        idle(2);
        step(0, 0, 1, 1);
        check("clrgo.bcd",     32'(bus.bcd),     32'h00);
        check("clrgo.running", 32'(bus.running), 32'd0);
        check("clrgo.cursor",  32'(bus.cursor),  32'b01);

        // Go coinciding with a tick: pause wins, first cycle after resume ticks.
        set_val(2);
        step(0, 0, 1, 0);
        idle(3);
        step(0, 0, 1, 0);
        check("gotick.bcd", 32'(bus.bcd), 32'h02);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        check("gotick.resume", 32'(bus.bcd), 32'h01);

        // Clear coinciding with expiry suppresses done.
        idle(3);
        step(0, 0, 0, 1);
        check("clrexp.done",  32'(bus.done),  32'd0);
        check("clrexp.alarm", 32'(bus.alarm), 32'd0);

        // Sel+inc together: inc hits old digit, cursor advances.
        step(1, 1, 0, 0);
        check("selinc.bcd",    32'(bus.bcd),    32'h01);
        check("selinc.cursor", 32'(bus.cursor), 32'b10);

        // Asynchronous reset mid-count at 37.
        set_val(37);
        check("r37.bcd", 32'(bus.bcd), 32'h37);
        step(0, 0, 1, 0);
        idle(2);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("arst.bcd",     32'(bus.bcd),     32'h00);
        check("arst.cursor",  32'(bus.cursor),  32'b01);
        check("arst.running", 32'(bus.running), 32'd0);
        check("arst.alarm",   32'(bus.alarm),   32'd0);
        check("arst.done",    32'(bus.done),    32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        cmp_model();

        // Randomized buttons against the reference model.
        for (int n = 0; n < 3000; n++) begin
            bit rs, ri, rg, rc;
            rc = ($urandom_range(0, 199) == 0);
            rg = ($urandom_range(0, 11) == 0);
            rs = ($urandom_range(0, 5) == 0);
            ri = ($urandom_range(0, 2) == 0);
            step(rs, ri, rg, rc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
